// File: rtl/des_perm_pipe.sv
// =============================================================================
// des_perm_pipe : DEPTH-stage DES IP/FP permutation pipe with valid/ready stalls.
// Optional macro DES_PERM_PARITY_EN adds in_par / sticky perr.  Rev 1.0
// =============================================================================
`default_nettype none

module des_perm_pipe #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:64]      in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:64]      out_data,
  output logic             out_mode,
`ifdef DES_PERM_PARITY_EN
  input  logic             in_par,
  output logic             perr,
`endif
  output logic [CNT_W-1:0] blk_cnt
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] mode_q;
  logic [1:64]      data_q [DEPTH];
  logic [CNT_W-1:0] blk_cnt_q;
  logic [CNT_W-1:0] blk_cnt_d;

  logic [DEPTH:0]   ld_chain;
  logic [1:64]      ip_perm;
  logic [1:64]      fp_perm;
  logic [1:64]      perm_sel;
  logic             in_fire;
  logic             out_fire;

  // Both permutations are fixed wiring; source indices resolve at elaboration.
  for (genvar j = 1; j <= 64; j++) begin : g_perm
    localparam int R      = (j - 1) >> 3;
    localparam int C      = (j - 1) & 7;
    localparam int IP_SRC = ((R < 4) ? (58 + 2 * R) : (49 + 2 * R)) - 8 * C;
    localparam int FP_SRC = (((C % 2) == 0) ? (40 + 4 * C) : (4 + 4 * C)) - R;
    assign ip_perm[j] = in_data[IP_SRC];
    assign fp_perm[j] = in_data[FP_SRC];
  end

  assign perm_sel = in_mode ? ip_perm : fp_perm;

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    ld_chain        = '0;
    ld_chain[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ld_chain[k] = !vld_q[k] || ld_chain[k + 1];
    end
  end

  assign in_ready  = !rst && ld_chain[0];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_mode  = mode_q[DEPTH-1];
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (ld_chain[0]) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= perm_sel;
          mode_q[0] <= in_mode;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld_chain[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            mode_q[k] <= mode_q[k-1];
          end
        end
      end
    end
  end

  assign blk_cnt_d = out_fire ? (blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;

`ifdef DES_PERM_PARITY_EN
  logic perr_q;
  logic perr_d;

  assign perr_d = perr_q || (in_fire && (in_par != (^in_data)));

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_des_perm_pipe.sv
// =============================================================================
// tb_des_perm_pipe : directed self-checking bench for des_perm_pipe (DEPTH=2).
// Parity scenario is compiled only when DES_PERM_PARITY_EN is defined.  Rev 1.0
// =============================================================================
`default_nettype none

module tb_des_perm_pipe;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:64]      in_data = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:64]      out_data;
  logic             out_mode;
  logic [CNT_W-1:0] blk_cnt;
`ifdef DES_PERM_PARITY_EN
  logic             in_par = 1'b0;
  logic             perr;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  des_perm_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
`ifdef DES_PERM_PARITY_EN
    .in_par    (in_par),
    .perr      (perr),
`endif
    .blk_cnt   (blk_cnt)
  );

  // Reference permutation straight from the published index formulas.
  function automatic logic [1:64] perm_model(input logic [1:64] d, input logic m);
    logic [1:64] res;
    int r, c, idx;
    res = '0;
    for (int j = 1; j <= 64; j++) begin
      r = (j - 1) >> 3;
      c = (j - 1) & 7;
      if (m) idx = ((r < 4) ? (58 + 2 * r) : (49 + 2 * r)) - 8 * c;
      else   idx = (((c % 2) == 0) ? (40 + 4 * c) : (4 + 4 * c)) - r;
      res[j] = d[idx];
    end
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    tick();
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_total++;
    if (out_data !== 64'h0 || out_mode !== 1'b0)
      $display("FAIL reset_out_data: got %h/%b expected 0/0", out_data, out_mode);
    else n_pass++;
    n_total++;
    if (blk_cnt !== 4'd0) $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready);
    else n_pass++;
`ifdef DES_PERM_PARITY_EN
    n_total++;
    if (perr !== 1'b0) $display("FAIL reset_perr: got %b expected 0", perr);
    else n_pass++;
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_known_answer;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h0123_4567_89AB_CDEF;
    in_mode   = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL ka_early_valid: got %b expected 0", out_valid);
    else n_pass++;
    in_data = 64'hCC00_CCFF_F0AA_F0AA;
    in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 64'hCC00_CCFF_F0AA_F0AA || out_mode !== 1'b1)
      $display("FAIL ka_ip: got v=%b %h m=%b expected v=1 cc00ccfff0aaf0aa m=1",
               out_valid, out_data, out_mode);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 64'h0123_4567_89AB_CDEF || out_mode !== 1'b0)
      $display("FAIL ka_fp: got v=%b %h m=%b expected v=1 0123456789abcdef m=0",
               out_valid, out_data, out_mode);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL ka_drained: got %b expected 0", out_valid);
    else n_pass++;
    n_total++;
    if (blk_cnt !== 4'd2) $display("FAIL ka_blk_cnt: got %0d expected 2", blk_cnt);
    else n_pass++;
  endtask

  task automatic test_bit_walk;
    logic [1:64] vec;
    logic [1:64] exp_v;
    logic        mb;
    do_reset();
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mb = (m != 0);
      for (int b = 1; b <= 64; b++) begin
        vec      = 64'h8000_0000_0000_0000 >> (b - 1);
        exp_v    = perm_model(vec, mb);
        in_data  = vec;
        in_mode  = mb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_data !== exp_v || out_mode !== mb)
          $display("FAIL bit_walk m=%0d b=%0d: got v=%b %h m=%b expected v=1 %h m=%b",
                   m, b, out_valid, out_data, out_mode, exp_v, mb);
        else n_pass++;
      end
    end
    in_data  = 64'h0000_0000_0100_0000;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 64'h8000_0000_0000_0000)
      $display("FAIL fp_bit40: got v=%b %h expected v=1 8000000000000000", out_valid, out_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure;
    logic [1:64] blk [5];
    logic        md  [5];
    logic [1:64] exp_v;
    int          acc;
    int          got;
    logic        fire_in;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      blk[i] = 64'h1357_9BDF_0246_8ACE ^ (64'h0F0F_1234_5678_A5A5 * (i + 1));
      md[i]  = (i % 2) == 0;
    end
    acc       = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1;
      in_data  = blk[acc];
      in_mode  = md[acc];
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    n_total++;
    if (acc !== 2) $display("FAIL bp_accepted: got %0d expected 2", acc);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b expected 0", in_ready);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready_full_drain: got %b expected 1", in_ready);
    else n_pass++;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin
        in_data = blk[acc];
        in_mode = md[acc];
      end
      @(negedge clk);
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        exp_v = perm_model(blk[got], md[got]);
        n_total++;
        if (out_data !== exp_v || out_mode !== md[got])
          $display("FAIL bp_order[%0d]: got %h m=%b expected %h m=%b",
                   got, out_data, out_mode, exp_v, md[got]);
        else n_pass++;
        got++;
      end
      if (fire_in) acc++;
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if (got !== 5) $display("FAIL bp_drain_count: got %0d expected 5", got);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || blk_cnt !== 4'd5)
      $display("FAIL bp_blk_cnt: got v=%b cnt=%0d expected v=0 cnt=5", out_valid, blk_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midflight;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_data   = 64'hDEAD_BEEF_0000_0001;
    tick();
    in_data = 64'hDEAD_BEEF_0000_0002;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL mid_inflight: got %b expected 1", out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL mid_in_ready_rst: got %b expected 0", in_ready);
    else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || blk_cnt !== 4'd0 || in_ready !== 1'b1)
      $display("FAIL mid_after_rst: got v=%b cnt=%0d rdy=%b expected v=0 cnt=0 rdy=1",
               out_valid, blk_cnt, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    n_total++;
    if (out_valid !== 1'b0 || blk_cnt !== 4'd0)
      $display("FAIL mid_dropped: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, blk_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int acc;
    do_reset();
    out_ready = 1'b1;
    acc       = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_mode  = (i % 3) == 0;
      in_data  = 64'hA5A5_0000_0000_0000 | 64'(i);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if (acc !== 17) $display("FAIL wrap_throughput: got %0d expected 17", acc);
    else n_pass++;
    tick();
    tick();
    tick();
    n_total++;
    if (blk_cnt !== 4'd1) $display("FAIL wrap_blk_cnt: got %0d expected 1", blk_cnt);
    else n_pass++;
  endtask

`ifdef DES_PERM_PARITY_EN
  task automatic test_parity;
    do_reset();
    out_ready = 1'b1;
    in_mode   = 1'b1;
    in_data   = 64'h3;
    in_par    = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_total++;
    if (perr !== 1'b0) $display("FAIL par_good: got %b expected 0", perr);
    else n_pass++;
    in_data  = 64'h1;
    in_par   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (perr !== 1'b1) $display("FAIL par_set: got %b expected 1", perr);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== perm_model(64'h1, 1'b1))
      $display("FAIL par_passthru: got v=%b %h expected v=1 %h",
               out_valid, out_data, perm_model(64'h1, 1'b1));
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (perr !== 1'b1 || blk_cnt !== 4'd2)
      $display("FAIL par_sticky: got perr=%b cnt=%0d expected 1/2", perr, blk_cnt);
    else n_pass++;
    do_reset();
    n_total++;
    if (perr !== 1'b0) $display("FAIL par_clear: got %b expected 0", perr);
    else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_known_answer();
    test_bit_walk();
    test_backpressure();
    test_reset_midflight();
    test_wrap();
`ifdef DES_PERM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_perm_pipe.md
# des_perm_pipe

Pipelined, mode-selectable DES bit-permutation unit with valid/ready flow control. It applies either the DES initial permutation (IP) or the final permutation (FP = IP⁻¹) per transaction. The mode travels alongside the data, so IP and FP blocks can be interleaved back-to-back. It sits at the input and output of the DES round datapath and replaces fixed, combinational-only permutation wiring where the round core needs registered, back-pressurable boundaries.

## Interface
- `DEPTH`, default 2: number of register stages, legal range 1..4. Latency is DEPTH cycles.
- `CNT_W`, default 16: width of the completed-block counter.
- `clk`, in, 1: sole clock. All logic updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: input block present.
- `in_ready`, out, 1: unit accepts the input this cycle.
- `in_data`, in, [1:64]: input block. Bit 1 is the MSB, per the DES convention.
- `in_mode`, in, 1: 0 selects FP, 1 selects IP.
- `out_valid`, out, 1: output block present.
- `out_ready`, in, 1: downstream accepts the output.
- `out_data`, out, [1:64]: permuted block.
- `out_mode`, out, 1: mode that produced `out_data`.
- `blk_cnt`, out, CNT_W: count of completed output handshakes.
- `perr`, out, 1: sticky parity error. Exists only with `DES_PERM_PARITY_EN`.
- `in_par`, in, 1: even-parity bit of `in_data`. Exists only with `DES_PERM_PARITY_EN`.

## Operation
- Permutation is applied combinationally to `in_data`, ahead of the stage-1 register. Stages 2..DEPTH carry data, mode and valid unchanged.
- Indexing uses 1-based output bit j, with r=(j-1)>>3 and c=(j-1)&7.
  - FP: out[j] = in[(c even ? 40+4c : 4+4c) − r].
  - IP: out[j] = in[(r<4 ? 58+2r : 49+2r) − 8c].
- Each stage holds a valid bit.
  - Stage k loads when it is empty or when it is handing off to stage k+1 (or the output) in the same cycle.
  - `in_ready` = !v1 || stage1 advances. This is a full-throughput stall pipeline, not a bubble-collapsing FIFO.
- Input acceptance is `in_valid && in_ready`. Output handshake is `out_valid && out_ready`.
- `out_valid`, `out_data` and `out_mode` come directly from the last stage's registers. There is no combinational path from `in_*` to `out_*`.
- `out_data` and `out_mode` hold stable while `out_valid && !out_ready`.
- Data in a stage whose valid bit is 0 is don't-care, but it resets to 0.
- `blk_cnt` increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (`rst`=1 at a rising edge) forces every stage valid to 0, `out_data` to 0, `out_mode` to 0, `blk_cnt` to 0 and `perr` to 0.
  - `in_ready` is 0 while `rst` is asserted, and 1 in the first cycle after reset.
  - Blocks in flight when reset hits mid-operation are dropped silently and not counted.
- Latency: a block accepted at edge n appears with `out_valid`=1 after edge n+DEPTH−1, i.e. it is visible DEPTH cycles after the input cycle, provided `out_ready` was held at 1.
- Throughput is one block per cycle with `out_ready` held at 1.
- Backpressure: with `out_ready`=0 the pipe fills.
  - `in_ready` falls to 0 when all DEPTH stages are valid.
  - At most DEPTH blocks are in flight.
- Simultaneous accept and emit on a full pipe is allowed: `in_ready`=1 whenever `out_ready`=1.
- Mode switches are allowed every cycle. Each block's `out_mode` equals its own `in_mode`.

## Configuration
- Macro: `DES_PERM_PARITY_EN`.
- Defined:
  - Adds the `in_par` input and the `perr` output.
  - On each input acceptance, if `in_par` ≠ XOR-reduce(`in_data`), `perr` sets to 1 on that edge.
  - `perr` clears only on `rst`.
  - Data flow is unaffected. Blocks with bad parity still pass through and are counted.
- Undefined: no `in_par` or `perr` ports, and no parity logic.

## Test plan
- IP known answer: `in_data`=0x0123456789ABCDEF with mode 1 → `out_data`=0xCC00CCFFF0AAF0AA and `out_mode`=1, exactly DEPTH cycles later.
- FP known answer and interleave: input 0xCC00CCFFF0AAF0AA with mode 0, sent the cycle after the IP block above → outputs appear in consecutive cycles: 0xCC00CCFFF0AAF0AA (mode 1), then 0x0123456789ABCDEF (mode 0).
- Bit walk: for each of the 64 single-hot inputs in both modes, compare against the index formulas. FP with only in[40] set (0x0000000001000000) → 0x8000000000000000.
- Backpressure (DEPTH=2): hold `out_ready`=0 and drive 5 valid blocks → exactly 2 accepted and `in_ready`=0. Then raise `out_ready` → blocks emerge in order with no loss or duplication, and `blk_cnt`=5 after all drain.
- Reset mid-flight: reset with 2 blocks in flight → next cycle `out_valid`=0, `blk_cnt`=0, `in_ready`=1.
- Counter wrap and parity (CNT_W=4, `DES_PERM_PARITY_EN`): 17 handshakes → `blk_cnt`=1. One input sent with wrong `in_par` → `perr`=1 from the next cycle, staying 1 until `rst`.
